// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer for a two-wide rename group.
// Each entry holds valid/done flags plus the new and previous physical destination.
// A registered release strobe per retire slot returns the previous mapping to the free pool.
// Optional feature: define ROB_DUAL_RETIRE_EN to retire up to two entries per cycle
// (head and head+1). Without it only the head retires and rt_flag_2/fp_i_2 stay at 0.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_flag_i,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic [5:0]    pd_1,
    input  logic [5:0]    pd_2,
    input  logic [5:0]    old_pd_1,
    input  logic [5:0]    old_pd_2,
    output logic          stall_o,
    output logic [IW-1:0] rob_idx_1,
    output logic [IW-1:0] rob_idx_2,
    input  logic          cmpl_flag_1,
    input  logic          cmpl_flag_2,
    input  logic [IW-1:0] cmpl_idx_1,
    input  logic [IW-1:0] cmpl_idx_2,
    output logic          rt_flag_1,
    output logic          rt_flag_2,
    output logic [5:0]    fp_i_1,
    output logic [5:0]    fp_i_2,
    output logic [IW:0]   count_o
);

    logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [IW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, done_q;
    logic [5:0]       pd_q     [DEPTH];
    logic [5:0]       old_pd_q [DEPTH];
    logic             rt_flag_1_q, rt_flag_1_d, rt_flag_2_q, rt_flag_2_d;
    logic [5:0]       fp_1_q, fp_1_d, fp_2_q, fp_2_d;
    logic             alloc_s, ret_1_s, ret_2_s;
    logic [1:0]       n_alloc_s, n_ret_s;
    logic [IW-1:0]    head_p1_s;

    assign head_p1_s = head_q + IW'(1'b1);

    // Dispatch view: free-space stall and the indices handed back to rename
    always_comb begin
        stall_o   = (count_q > (IW+1)'(DEPTH - 2));
        rob_idx_1 = tail_q;
        if (valid_1) begin
            rob_idx_2 = tail_q + IW'(1'b1);
        end else begin
            rob_idx_2 = tail_q;
        end
        alloc_s = en_flag_i & ~stall_o;
        if (alloc_s) begin
            n_alloc_s = {1'b0, valid_1} + {1'b0, valid_2};
        end else begin
            n_alloc_s = 2'd0;
        end
    end

    // Retire selection, release payload and pointer/occupancy next state
    always_comb begin
        ret_1_s     = valid_q[head_q] & done_q[head_q];
        ret_2_s     = 1'b0;
        rt_flag_1_d = ret_1_s & (pd_q[head_q] != 6'd0);
        if (rt_flag_1_d) begin
            fp_1_d = old_pd_q[head_q];
        end else begin
            fp_1_d = 6'd0;
        end
        rt_flag_2_d = 1'b0;
        fp_2_d      = 6'd0;
`ifdef ROB_DUAL_RETIRE_EN
        ret_2_s     = ret_1_s & valid_q[head_p1_s] & done_q[head_p1_s];
        rt_flag_2_d = ret_2_s & (pd_q[head_p1_s] != 6'd0);
        if (rt_flag_2_d) begin
            fp_2_d = old_pd_q[head_p1_s];
        end else begin
            fp_2_d = 6'd0;
        end
`endif
        n_ret_s = {1'b0, ret_1_s} + {1'b0, ret_2_s};
        head_d  = head_q + IW'(n_ret_s);
        tail_d  = tail_q + IW'(n_alloc_s);
        count_d = count_q + (IW+1)'(n_alloc_s) - (IW+1)'(n_ret_s);
    end

    // Entry array, pointers and registered release strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= {IW{1'b0}};
            tail_q      <= {IW{1'b0}};
            count_q     <= {(IW+1){1'b0}};
            valid_q     <= {DEPTH{1'b0}};
            done_q      <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pd_q[i]     <= 6'd0;
                old_pd_q[i] <= 6'd0;
            end
            rt_flag_1_q <= 1'b0;
            rt_flag_2_q <= 1'b0;
            fp_1_q      <= 6'd0;
            fp_2_q      <= 6'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rt_flag_1_q <= rt_flag_1_d;
            rt_flag_2_q <= rt_flag_2_d;
            fp_1_q      <= fp_1_d;
            fp_2_q      <= fp_2_d;
            // completions only land on live entries
            if (cmpl_flag_1 && valid_q[cmpl_idx_1]) begin
                done_q[cmpl_idx_1] <= 1'b1;
            end
            if (cmpl_flag_2 && valid_q[cmpl_idx_2]) begin
                done_q[cmpl_idx_2] <= 1'b1;
            end
            if (ret_1_s) begin
                valid_q[head_q] <= 1'b0;
            end
            if (ret_2_s) begin
                valid_q[head_p1_s] <= 1'b0;
            end
            // allocation targets free slots only, so it never collides with the writes above
            if (alloc_s && valid_1) begin
                valid_q[tail_q]  <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                pd_q[tail_q]     <= pd_1;
                old_pd_q[tail_q] <= old_pd_1;
            end
            if (alloc_s && valid_2) begin
                valid_q[rob_idx_2]  <= 1'b1;
                done_q[rob_idx_2]   <= 1'b0;
                pd_q[rob_idx_2]     <= pd_2;
                old_pd_q[rob_idx_2] <= old_pd_2;
            end
        end
    end

    assign rt_flag_1 = rt_flag_1_q;
    assign rt_flag_2 = rt_flag_2_q;
    assign fp_i_1    = fp_1_q;
    assign fp_i_2    = fp_2_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic against a
// program-order queue model of the reorder buffer.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_flag_i, valid_1, valid_2;
    logic [5:0]    pd_1, pd_2, old_pd_1, old_pd_2;
    logic          stall_o;
    logic [IW-1:0] rob_idx_1, rob_idx_2;
    logic          cmpl_flag_1, cmpl_flag_2;
    logic [IW-1:0] cmpl_idx_1, cmpl_idx_2;
    logic          rt_flag_1, rt_flag_2;
    logic [5:0]    fp_i_1, fp_i_2;
    logic [IW:0]   count_o;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .en_flag_i(en_flag_i),
        .valid_1(valid_1), .valid_2(valid_2),
        .pd_1(pd_1), .pd_2(pd_2), .old_pd_1(old_pd_1), .old_pd_2(old_pd_2),
        .stall_o(stall_o), .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
        .cmpl_flag_1(cmpl_flag_1), .cmpl_flag_2(cmpl_flag_2),
        .cmpl_idx_1(cmpl_idx_1), .cmpl_idx_2(cmpl_idx_2),
        .rt_flag_1(rt_flag_1), .rt_flag_2(rt_flag_2),
        .fp_i_1(fp_i_1), .fp_i_2(fp_i_2), .count_o(count_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: indices in program order plus per-index payload
    int order[$];
    int m_pd [DEPTH];
    int m_opd[DEPTH];
    bit m_done[DEPTH];
    int m_tail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        order.delete();
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
    endtask

    function automatic bit in_rob(input int idx);
        foreach (order[k]) if (order[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check strobes
    task automatic step(input bit en, input bit v1, input bit v2,
                        input int p1, input int p2, input int o1, input int o2,
                        input bit c1, input int i1, input bit c2, input int i2);
        bit st, r1, r2, f1, f2;
        int fp1, fp2;
        @(negedge clk);
        en_flag_i = en; valid_1 = v1; valid_2 = v2;
        pd_1 = 6'(p1); pd_2 = 6'(p2); old_pd_1 = 6'(o1); old_pd_2 = 6'(o2);
        cmpl_flag_1 = c1; cmpl_idx_1 = IW'(i1);
        cmpl_flag_2 = c2; cmpl_idx_2 = IW'(i2);
        #1;
        st = (order.size() > DEPTH - 2);
        chk("stall", stall_o, st);
        chk("count", count_o, order.size());
        chk("rob_idx_1", rob_idx_1, m_tail);
        chk("rob_idx_2", rob_idx_2, v1 ? (m_tail + 1) % DEPTH : m_tail);
        r1 = 0; r2 = 0; f1 = 0; f2 = 0; fp1 = 0; fp2 = 0;
        if (order.size() > 0 && m_done[order[0]]) begin
            r1 = 1;
            f1 = (m_pd[order[0]] != 0);
            if (f1) fp1 = m_opd[order[0]];
`ifdef ROB_DUAL_RETIRE_EN
            if (order.size() > 1 && m_done[order[1]]) begin
                r2 = 1;
                f2 = (m_pd[order[1]] != 0);
                if (f2) fp2 = m_opd[order[1]];
            end
`endif
        end
        if (r1) void'(order.pop_front());
        if (r2) void'(order.pop_front());
        if (c1 && in_rob(i1)) m_done[i1] = 1'b1;
        if (c2 && in_rob(i2)) m_done[i2] = 1'b1;
        if (en && !st) begin
            if (v1) begin
                m_pd[m_tail] = p1; m_opd[m_tail] = o1; m_done[m_tail] = 1'b0;
                order.push_back(m_tail); m_tail = (m_tail + 1) % DEPTH;
            end
            if (v2) begin
                m_pd[m_tail] = p2; m_opd[m_tail] = o2; m_done[m_tail] = 1'b0;
                order.push_back(m_tail); m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        chk("rt_flag_1", rt_flag_1, f1);
        chk("rt_flag_2", rt_flag_2, f2);
        if (f1 || !r1) chk("fp_i_1", fp_i_1, fp1);
        if (f2 || !r2) chk("fp_i_2", fp_i_2, fp2);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic comp(input int a, input int b);
        step(0, 0, 0, 0, 0, 0, 0, 1, a, 1, b);
    endtask

    task automatic alloc2();
        step(1, 1, 1, $urandom_range(63, 1), $urandom_range(63, 1),
             $urandom_range(63, 0), $urandom_range(63, 0), 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on the next falling edge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_rt1", rt_flag_1, 0);
        chk("rst_rt2", rt_flag_2, 0);
        chk("rst_fp1", fp_i_1, 0);
        chk("rst_fp2", fp_i_2, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int a, b, guard;
        guard = 0;
        while (order.size() > 0 && guard < 200) begin
            a = order[$urandom_range(order.size() - 1)];
            b = order[$urandom_range(order.size() - 1)];
            comp(a, b);
            guard++;
        end
        idle();
        chk("drain_count", count_o, order.size());
    endtask

    initial begin
        en_flag_i = 0; valid_1 = 0; valid_2 = 0;
        pd_1 = 0; pd_2 = 0; old_pd_1 = 0; old_pd_2 = 0;
        cmpl_flag_1 = 0; cmpl_flag_2 = 0; cmpl_idx_1 = 0; cmpl_idx_2 = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        chk("reset_count", count_o, 0);
        chk("reset_stall", stall_o, 0);
        chk("reset_idx", rob_idx_1, 0);
        chk("reset_rt1", rt_flag_1, 0);
        chk("reset_rt2", rt_flag_2, 0);
        chk("reset_fp1", fp_i_1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // first group after reset gets indices 0/1
        step(1, 1, 1, 33, 34, 5, 6, 0, 0, 0, 0);
        chk("alloc_count2", count_o, 2);

        // complete idx 1 then idx 0, then observe release
        comp(1, 1);
        comp(0, 0);
        idle();
        chk("rel_fp1_first", fp_i_1, 5);
`ifdef ROB_DUAL_RETIRE_EN
        chk("rel_fp2_first", fp_i_2, 6);
`else
        idle();
        chk("rel_fp1_second", fp_i_1, 6);
`endif
        idle();

        // fill from a clean reset, then try one more group
        @(posedge clk);
        async_reset();
        for (int g = 0; g < 8; g++) alloc2();
        chk("full_count", count_o, 16);
        chk("full_stall", stall_o, 1);
        alloc2();
        chk("full_hold_idx", rob_idx_1, 0);

        // retire the four oldest, then allocate across the wrap point
        comp(0, 1);
        comp(2, 3);
        for (int k = 0; k < 8 && order.size() > 12; k++) idle();
        chk("wrap_count", count_o, 12);
        alloc2();
        step(1, 1, 0, 9, 0, 10, 0, 0, 0, 0, 0);
        chk("stall_at_15", stall_o, 1);
        drain();

        // entry without destination
        step(1, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        comp(order[0], order[0]);
        idle();
        idle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int a, b;
            bit ca, cb;
            ca = $urandom_range(1, 0);
            cb = $urandom_range(1, 0);
            a = (order.size() > 0 && $urandom_range(3, 0) != 0) ?
                order[$urandom_range(order.size() - 1)] : $urandom_range(DEPTH - 1, 0);
            b = (order.size() > 0 && $urandom_range(3, 0) != 0) ?
                order[$urandom_range(order.size() - 1)] : $urandom_range(DEPTH - 1, 0);
            step($urandom_range(3, 0) != 0, $urandom_range(1, 0), $urandom_range(1, 0),
                 ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(63, 1),
                 ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(63, 1),
                 $urandom_range(63, 0), $urandom_range(63, 0), ca, a, cb, b);
        end
        drain();

        // reset with five pending entries, two of them about to retire
        alloc2();
        alloc2();
        step(1, 1, 0, 44, 0, 45, 0, 0, 0, 0, 0);
        comp(order[0], order[1]);
        async_reset();
        for (int k = 0; k < 4; k++) idle();
        step(1, 1, 1, 20, 21, 22, 23, 0, 0, 0, 0);
        chk("post_reset_count", count_o, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
